// File: rtl/clock_gen_multi.sv
// -----------------------------------------------------------------------------
// clock_gen_multi
//   Divides the reference clock into NCH independent derived clocks. Each
//   channel has a programmable period, high time and start phase. A channel
//   starts after its phase delay. A disable always lets the current period
//   finish, so a pulse is never cut short.
//
//   Config interface: cfg_we is a single-cycle write strobe with no
//   backpressure. Every cycle it is high, the write is accepted. Writes go to
//   a shadow copy. The live copy picks up the shadow while the channel is
//   idle, or at a period boundary. A write made in the boundary cycle itself
//   is already visible at that boundary.
//
// Ports
//   clk        in   reference clock, all logic on posedge
//   rst_n      in   asynchronous active-low reset
//   en         in   per-channel enable (level)
//   cfg_we     in   config write strobe
//   cfg_ch     in   target channel (values >= NCH are ignored)
//   cfg_sel    in   0=period 1=high 2=phase 3=reserved (ignored)
//   cfg_wdata  in   config write data
//   clk_out    out  generated clocks (registered)
//   running    out  channel in DELAY, RUN or DRAIN (registered)
//   tick       out  first cycle of every generated period (registered)
//
// Each channel's FSM state is held in g_ch[i].r_state for observation.
// -----------------------------------------------------------------------------
module clock_gen_multi #(
  parameter int NCH        = 4,
  parameter int CNT_W      = 8,
  parameter int DEF_PERIOD = 4,
  parameter int DEF_HIGH   = 2,
  parameter int DEF_PHASE  = 0
) (
  input  logic                                    clk,
  input  logic                                    rst_n,
  input  logic [NCH-1:0]                          en,
  input  logic                                    cfg_we,
  input  logic [((NCH > 1) ? $clog2(NCH) : 1)-1:0] cfg_ch,
  input  logic [1:0]                              cfg_sel,
  input  logic [CNT_W-1:0]                        cfg_wdata,
  output logic [NCH-1:0]                          clk_out,
  output logic [NCH-1:0]                          running,
  output logic [NCH-1:0]                          tick
);

  localparam int CH_W = (NCH > 1) ? $clog2(NCH) : 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DELAY = 2'd1,
    ST_RUN   = 2'd2,
    ST_DRAIN = 2'd3
  } state_t;

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    state_t           r_state, w_state_nxt;
    logic [CNT_W-1:0] r_pcnt, w_pcnt_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic [CNT_W-1:0] r_sh_per, r_sh_high, r_sh_phase;
    logic [CNT_W-1:0] w_sh_per_nxt, w_sh_high_nxt, w_sh_phase_nxt;
    logic [CNT_W-1:0] r_per, r_high, r_phase;
    logic [CNT_W-1:0] w_per_nxt, w_high_nxt, w_phase_nxt;
    logic [CNT_W-1:0] w_per_eff;
    logic             r_clk, r_run, r_tick;
    logic             w_wr, w_active, w_last, w_load, w_act_nxt;

    // Shadow registers, including this cycle's write.
    assign w_wr           = cfg_we && (cfg_ch == CH_W'(g));
    assign w_sh_per_nxt   = (w_wr && cfg_sel == 2'd0) ? cfg_wdata : r_sh_per;
    assign w_sh_high_nxt  = (w_wr && cfg_sel == 2'd1) ? cfg_wdata : r_sh_high;
    assign w_sh_phase_nxt = (w_wr && cfg_sel == 2'd2) ? cfg_wdata : r_sh_phase;

    // A period shorter than 2 cycles cannot have both a high and a low phase.
    assign w_per_eff = (r_per < CNT_W'(2)) ? CNT_W'(2) : r_per;
    assign w_active  = (r_state == ST_RUN) || (r_state == ST_DRAIN);
    assign w_last    = w_active && (r_cnt == w_per_eff - CNT_W'(1));

    // The live config changes only while idle or at a period boundary. The
    // next shadow value is used so a boundary-cycle write lands immediately.
    assign w_load      = (r_state == ST_IDLE) || w_last;
    assign w_per_nxt   = w_load ? w_sh_per_nxt   : r_per;
    assign w_high_nxt  = w_load ? w_sh_high_nxt  : r_high;
    assign w_phase_nxt = w_load ? w_sh_phase_nxt : r_phase;

    always_comb begin
      w_state_nxt = r_state;
      w_pcnt_nxt  = r_pcnt;
      w_cnt_nxt   = r_cnt;
      unique case (r_state)
        ST_IDLE: begin
          if (en[g]) begin
            w_state_nxt = ST_DELAY;
            w_pcnt_nxt  = w_phase_nxt;
          end
        end
        ST_DELAY: begin
          if (!en[g]) begin
            w_state_nxt = ST_IDLE;
          end else if (r_pcnt == '0) begin
            w_state_nxt = ST_RUN;
            w_cnt_nxt   = '0;
          end else begin
            w_pcnt_nxt = r_pcnt - CNT_W'(1);
          end
        end
        ST_RUN, ST_DRAIN: begin
          // RUN and DRAIN count identically. A channel that is disabled at
          // the end of a period stops there instead of starting a new one.
          if (w_last) begin
            w_cnt_nxt   = '0;
            w_state_nxt = en[g] ? ST_RUN : ST_IDLE;
          end else begin
            w_cnt_nxt   = r_cnt + CNT_W'(1);
            w_state_nxt = en[g] ? ST_RUN : ST_DRAIN;
          end
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end

    assign w_act_nxt = (w_state_nxt == ST_RUN) || (w_state_nxt == ST_DRAIN);

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_state    <= ST_IDLE;
        r_pcnt     <= '0;
        r_cnt      <= '0;
        r_sh_per   <= CNT_W'(DEF_PERIOD);
        r_sh_high  <= CNT_W'(DEF_HIGH);
        r_sh_phase <= CNT_W'(DEF_PHASE);
        r_per      <= CNT_W'(DEF_PERIOD);
        r_high     <= CNT_W'(DEF_HIGH);
        r_phase    <= CNT_W'(DEF_PHASE);
        r_clk      <= 1'b0;
        r_run      <= 1'b0;
        r_tick     <= 1'b0;
      end else begin
        r_state    <= w_state_nxt;
        r_pcnt     <= w_pcnt_nxt;
        r_cnt      <= w_cnt_nxt;
        r_sh_per   <= w_sh_per_nxt;
        r_sh_high  <= w_sh_high_nxt;
        r_sh_phase <= w_sh_phase_nxt;
        r_per      <= w_per_nxt;
        r_high     <= w_high_nxt;
        r_phase    <= w_phase_nxt;
        // The outputs are decoded from the next state, so they line up with
        // the counter value they describe.
        r_clk      <= w_act_nxt && (w_cnt_nxt < w_high_nxt);
        r_tick     <= w_act_nxt && (w_cnt_nxt == '0);
        r_run      <= (w_state_nxt != ST_IDLE);
      end
    end

    assign clk_out[g] = r_clk;
    assign running[g] = r_run;
    assign tick[g]    = r_tick;
  end

endmodule

// File: tb/tb_clock_gen_multi.sv
module tb_clock_gen_multi;
  localparam int NCH   = 4;
  localparam int CNT_W = 8;
  localparam int W     = 3 * NCH;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [NCH-1:0]   en;
  logic             cfg_we;
  logic [1:0]       cfg_ch;
  logic [1:0]       cfg_sel;
  logic [CNT_W-1:0] cfg_wdata;
  logic [NCH-1:0]   clk_out, running, tick;

  int n_checks = 0;
  int n_fail   = 0;

  logic [W-1:0] exp_q[$];
  logic [31:0]  cap_clk, cap_tick, cap_run;

  clock_gen_multi #(
    .NCH(NCH), .CNT_W(CNT_W), .DEF_PERIOD(4), .DEF_HIGH(2), .DEF_PHASE(0)
  ) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .cfg_we(cfg_we), .cfg_ch(cfg_ch),
    .cfg_sel(cfg_sel), .cfg_wdata(cfg_wdata), .clk_out(clk_out),
    .running(running), .tick(tick)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_cfg(input int ch, input int sel, input int data);
    cfg_we    = 1'b1;
    cfg_ch    = 2'(ch);
    cfg_sel   = 2'(sel);
    cfg_wdata = CNT_W'(data);
  endtask

  task automatic clr_cfg();
    cfg_we = 1'b0;
  endtask

  // Called just after a negedge; the write is taken at the next posedge.
  task automatic cfg_write(input int ch, input int sel, input int data);
    set_cfg(ch, sel, data);
    @(negedge clk);
    clr_cfg();
  endtask

  task automatic clear_cap();
    cap_clk  = '0;
    cap_tick = '0;
    cap_run  = '0;
  endtask

  task automatic sample(input int ch, input int i);
    cap_clk[i]  = clk_out[ch];
    cap_tick[i] = tick[ch];
    cap_run[i]  = running[ch];
  endtask

  // ---------------- behavioural model ----------------
  // Per channel: pending config, config of the current period, whether the
  // channel is active, cycles left before the first period starts, and the
  // position inside the current period (-1 while waiting out the phase).
  int m_sh_per[NCH], m_sh_high[NCH], m_sh_phase[NCH];
  int m_per[NCH], m_high[NCH];
  int m_on[NCH], m_lead[NCH], m_pos[NCH];

  function automatic int eff_per(input int p);
    return (p < 2) ? 2 : p;
  endfunction

  always @(posedge clk) begin
    logic [NCH-1:0] ec, et, er;
    for (int c = 0; c < NCH; c++) begin
      if (!rst_n) begin
        m_sh_per[c] = 4; m_sh_high[c] = 2; m_sh_phase[c] = 0;
        m_per[c] = 4; m_high[c] = 2;
        m_on[c] = 0; m_lead[c] = 0; m_pos[c] = -1;
      end else begin
        if (cfg_we && int'(cfg_ch) == c) begin
          if (cfg_sel == 2'd0) m_sh_per[c] = int'(cfg_wdata);
          if (cfg_sel == 2'd1) m_sh_high[c] = int'(cfg_wdata);
          if (cfg_sel == 2'd2) m_sh_phase[c] = int'(cfg_wdata);
        end
        if (m_on[c] == 0) begin
          m_per[c]  = eff_per(m_sh_per[c]);
          m_high[c] = m_sh_high[c];
          if (en[c]) begin
            m_on[c]   = 1;
            m_lead[c] = m_sh_phase[c] + 1;
            m_pos[c]  = -1;
          end
        end else if (m_pos[c] < 0) begin
          if (!en[c]) begin
            m_on[c] = 0;
          end else begin
            m_lead[c]--;
            if (m_lead[c] == 0) m_pos[c] = 0;
          end
        end else if (m_pos[c] == m_per[c] - 1) begin
          m_per[c]  = eff_per(m_sh_per[c]);
          m_high[c] = m_sh_high[c];
          if (en[c]) m_pos[c] = 0;
          else begin
            m_on[c]  = 0;
            m_pos[c] = -1;
          end
        end else begin
          m_pos[c]++;
        end
      end
      er[c] = (m_on[c] != 0);
      ec[c] = (m_on[c] != 0) && (m_pos[c] >= 0) && (m_pos[c] < m_high[c]);
      et[c] = (m_on[c] != 0) && (m_pos[c] == 0);
    end
    exp_q.push_back({er, et, ec});
  end

  // ---------------- scoreboard compare ----------------
  always @(negedge clk) begin
    logic [W-1:0] e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("cycle clk_out", 32'(clk_out), 32'(e[NCH-1:0]));
      check("cycle tick",    32'(tick),    32'(e[2*NCH-1:NCH]));
      check("cycle running", 32'(running), 32'(e[3*NCH-1:2*NCH]));
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #100000;
    n_fail++;
    $display("FAIL watchdog: stimulus did not complete, got timeout expected completion");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // ---------------- directed stimulus ----------------
  initial begin
    rst_n = 1'b0; en = '0; cfg_we = 1'b0; cfg_ch = '0; cfg_sel = '0; cfg_wdata = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // 1: idle after reset
    clear_cap();
    repeat (10) begin
      @(negedge clk);
      cap_clk[0]  = cap_clk[0]  | (|clk_out);
      cap_tick[0] = cap_tick[0] | (|tick);
      cap_run[0]  = cap_run[0]  | (|running);
    end
    check("t1 clk_out idle", cap_clk, 32'h0);
    check("t1 tick idle",    cap_tick, 32'h0);
    check("t1 running idle", cap_run, 32'h0);

    // 2: defaults on ch0, 2 high / 2 low starting one edge after enable
    en[0] = 1'b1;
    clear_cap();
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      sample(0, i);
    end
    check("t2 clk_out[0]", cap_clk,  32'h066);
    check("t2 tick[0]",    cap_tick, 32'h022);
    check("t2 running[0]", cap_run,  32'h1FF);

    // 3: ch1 period 10, high 3, phase 5; disabled mid-high
    cfg_write(1, 0, 10);
    cfg_write(1, 1, 3);
    cfg_write(1, 2, 5);
    en[1] = 1'b1;
    clear_cap();
    for (int i = 0; i < 18; i++) begin
      @(negedge clk);
      sample(1, i);
      if (i == 7) en[1] = 1'b0;
    end
    check("t3 clk_out[1]", cap_clk,  32'h001C0);
    check("t3 tick[1]",    cap_tick, 32'h00040);
    check("t3 running[1]", cap_run,  32'h0FFFF);

    // 4: ch2 period changes mid-period and in boundary cycles
    en[2] = 1'b1;
    clear_cap();
    for (int i = 0; i < 23; i++) begin
      @(negedge clk);
      sample(2, i);
      case (i)
        2:  set_cfg(2, 0, 6);
        10: set_cfg(2, 0, 4);
        14: set_cfg(2, 0, 6);
        3, 11, 15: clr_cfg();
        default: ;
      endcase
    end
    check("t4 clk_out[2]", cap_clk,  32'h619866);
    check("t4 tick[2]",    cap_tick, 32'h208822);
    en[2] = 1'b0;
    repeat (8) @(negedge clk);

    // 5a: high=0 -> ticks but no clock
    cfg_write(3, 1, 0);
    en[3] = 1'b1;
    clear_cap();
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      sample(3, i);
    end
    check("t5a clk_out[3]", cap_clk,  32'h000);
    check("t5a tick[3]",    cap_tick, 32'h022);
    en[3] = 1'b0;
    repeat (8) @(negedge clk);

    // 5b: high=200, period=8 -> constant high
    cfg_write(3, 1, 200);
    cfg_write(3, 0, 8);
    en[3] = 1'b1;
    clear_cap();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      sample(3, i);
    end
    check("t5b clk_out[3]", cap_clk,  32'h3FE);
    check("t5b tick[3]",    cap_tick, 32'h202);
    en[3] = 1'b0;
    repeat (12) @(negedge clk);

    // 5c: period=1 behaves as period=2
    cfg_write(3, 0, 1);
    cfg_write(3, 1, 1);
    en[3] = 1'b1;
    clear_cap();
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      sample(3, i);
    end
    check("t5c clk_out[3]", cap_clk,  32'h0AA);
    check("t5c tick[3]",    cap_tick, 32'h0AA);
    en[3] = 1'b0;
    repeat (6) @(negedge clk);

    // 6a: en 1->0->1 inside DRAIN, no gap
    en[0] = 1'b0;
    repeat (8) @(negedge clk);
    en[0] = 1'b1;
    clear_cap();
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      sample(0, i);
      if (i == 2) en[0] = 1'b0;
      if (i == 3) en[0] = 1'b1;
    end
    check("t6a clk_out[0]", cap_clk,  32'h066);
    check("t6a running[0]", cap_run,  32'h1FF);
    check("t6a tick[0]",    cap_tick, 32'h022);

    // 6b: 2-cycle enable with phase 5 -> no pulse
    en[1] = 1'b1;
    clear_cap();
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      sample(1, i);
      if (i == 1) en[1] = 1'b0;
    end
    check("t6b clk_out[1]", cap_clk,  32'h00);
    check("t6b running[1]", cap_run,  32'h03);
    check("t6b tick[1]",    cap_tick, 32'h00);

    // 6c: async reset while ch0 is high
    @(negedge clk);
    check("t6c pre-reset clk_out[0]", 32'(clk_out[0]), 32'h1);
    #1 rst_n = 1'b0;
    #1;
    check("t6c async clk_out", 32'(clk_out), 32'h0);
    check("t6c async running", 32'(running), 32'h0);
    check("t6c async tick",    32'(tick),    32'h0);
    en = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    check("t6c post-reset running", 32'(running), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
